// File: rtl/div.sv
// Iterative 32-bit signed/unsigned restoring divider for DIV/DIVU.
// Produces one quotient bit per clock and returns {remainder, quotient}.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [64:0] work, work_nxt;
  logic [31:0] divisor, divisor_nxt;
  logic        dividend_neg, dividend_neg_nxt;
  logic        divisor_neg, divisor_neg_nxt;
  logic        signed_op, signed_op_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;

  logic [31:0] abs_a, abs_b, quot, rem;
  logic [32:0] trial;

  // Magnitudes are only taken for signed operations with a negative operand.
  assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign trial = {1'b0, work[63:32]} - {1'b0, divisor};

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quot = (signed_op && (dividend_neg ^ divisor_neg)) ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem  = (signed_op && dividend_neg) ? (~work[64:33] + 32'd1) : work[64:33];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FREE;
      cnt          <= 6'd0;
      work         <= 65'd0;
      divisor      <= 32'd0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      signed_op    <= 1'b0;
      result_o     <= 64'd0;
      ready_o      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      work         <= work_nxt;
      divisor      <= divisor_nxt;
      dividend_neg <= dividend_neg_nxt;
      divisor_neg  <= divisor_neg_nxt;
      signed_op    <= signed_op_nxt;
      result_o     <= result_nxt;
      ready_o      <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    work_nxt         = work;
    divisor_nxt      = divisor;
    dividend_neg_nxt = dividend_neg;
    divisor_neg_nxt  = divisor_neg;
    signed_op_nxt    = signed_op;
    result_nxt       = result_o;
    ready_nxt        = ready_o;

    if (annul_i) begin
      state_nxt  = FREE;
      cnt_nxt    = 6'd0;
      result_nxt = 64'd0;
      ready_nxt  = 1'b0;
    end else begin
      case (state)
        FREE: begin
          cnt_nxt    = 6'd0;
          result_nxt = 64'd0;
          ready_nxt  = 1'b0;
          if (start_i) begin
            if (opdata2_i == 32'd0) begin
              state_nxt = BYZERO;
            end else begin
              state_nxt        = ON;
              work_nxt         = {32'd0, abs_a, 1'b0};
              divisor_nxt      = abs_b;
              dividend_neg_nxt = opdata1_i[31];
              divisor_neg_nxt  = opdata2_i[31];
              signed_op_nxt    = signed_div_i;
            end
          end
        end
        BYZERO: begin
          state_nxt  = END;
          result_nxt = 64'd0;
          ready_nxt  = 1'b1;
        end
        ON: begin
          // Count reaching 32 means all bits are in; this edge only corrects signs.
          if (cnt != 6'd32) begin
            work_nxt = trial[32] ? {work[63:0], 1'b0} : {trial[31:0], work[31:0], 1'b1};
            cnt_nxt  = cnt + 6'd1;
          end else begin
            state_nxt  = END;
            result_nxt = {rem, quot};
            ready_nxt  = 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            state_nxt  = FREE;
            cnt_nxt    = 6'd0;
            result_nxt = 64'd0;
            ready_nxt  = 1'b0;
          end
        end
        default: begin
          state_nxt  = FREE;
          cnt_nxt    = 6'd0;
          result_nxt = 64'd0;
          ready_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative divider: latency, signed
// and unsigned results, divide by zero, annul/reset recovery and hold.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_checks;
  int n_fail;
  int edges;
  logic saw_ready;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a request and lets the accepting edge (E0) happen.
  task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
  endtask

  // Counts edges after E0 until ready is seen, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 80) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_op(input string tag);
    start = 1'b0;
    tick();
    check_output({tag, " ready drop"}, {63'd0, ready}, 64'd0);
    check_output({tag, " result clear"}, result, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int exp_edges, input logic [63:0] exp_result);
    int n;
    apply_stimulus(sgn, a, b);
    wait_ready(n);
    check_output({tag, " latency"}, 64'(n), 64'(exp_edges));
    check_output({tag, " result"}, result, exp_result);
    finish_op(tag);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    check_output("reset result", result, 64'd0);
    check_output("reset ready", {63'd0, ready}, 64'd0);
    rst = 1'b1;
    tick();

    // Unsigned 100/7 with hold in the done state
    apply_stimulus(1'b0, 32'd100, 32'd7);
    wait_ready(edges);
    check_output("u100/7 latency", 64'(edges), 64'd33);
    check_output("u100/7 result", result, 64'h00000002_0000000E);
    repeat (5) tick();
    check_output("hold ready", {63'd0, ready}, 64'd1);
    check_output("hold result", result, 64'h00000002_0000000E);
    finish_op("u100/7");

    do_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
    do_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    do_op("uFFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'd2, 33, 64'h00000001_7FFFFFFC);
    do_op("s-100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 33, 64'hFFFFFFFE_FFFFFFF2);
    do_op("uFFFFFFFF/16", 1'b0, 32'hFFFFFFFF, 32'h10, 33, 64'h0000000F_0FFFFFFF);
    do_op("u5/0", 1'b0, 32'd5, 32'd0, 1, 64'd0);
    do_op("s-5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 1, 64'd0);
    do_op("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);

    // Operand changes after acceptance must not disturb the result
    apply_stimulus(1'b0, 32'd1000, 32'd7);
    repeat (5) tick();
    opdata1    = 32'hDEADBEEF;
    opdata2    = 32'd0;
    signed_div = 1'b1;
    wait_ready(edges);
    check_output("opchg latency", 64'(edges), 64'd28);
    check_output("opchg result", result, 64'h00000006_0000008E);
    finish_op("opchg");

    // Annul at E10
    apply_stimulus(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    check_output("annul pre ready", {63'd0, ready}, 64'd0);
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    check_output("annul result", result, 64'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    check_output("annul no ready", {63'd0, saw_ready}, 64'd0);
    do_op("post-annul", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);

    // Reset at E10
    apply_stimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    repeat (9) tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    rst = 1'b1;
    check_output("midrst result", result, 64'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (ready) saw_ready = 1'b1;
    end
    check_output("midrst no ready", {63'd0, saw_ready}, 64'd0);
    do_op("post-rst", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
